mini_i_fetch: RTL

Instruction fetch stage directly upstream of mini_i_cache. It holds the program counter and issues sequential fetch addresses on the ir_addr valid/ready channel. It accepts in-order instruction words on the ir_data channel, tags each with its PC, and buffers them in a small FIFO toward decode. A redirect (branch/exception) retargets the PC and discards stale instructions using an epoch bit.

---
 rtl/mini_i_fetch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mini_i_fetch.sv
// Instruction fetch stage: PC, credit-limited fetch requests, epoch-tagged responses, decode FIFO.
// Optional define MINI_I_FETCH_STATS_EN adds the stat_dropped counter port.
module mini_i_fetch #(
    parameter int data_width      = 32,
    parameter int addr_width      = 32,
    parameter logic [addr_width-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [addr_width-1:0] redirect_pc,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [addr_width-1:0] ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [data_width-1:0] ir_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [data_width-1:0] inst_data,
    output logic [addr_width-1:0] inst_pc
`ifdef MINI_I_FETCH_STATS_EN
    ,
    output logic [15:0]           stat_dropped
`endif
);

    localparam int BYTES = data_width / 8;
    localparam logic [addr_width-1:0] PC_INC     = addr_width'(BYTES);
    localparam logic [addr_width-1:0] ALIGN_MASK = addr_width'(BYTES - 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TW-1:0] TLAST = TW'(MAX_OUTSTANDING - 1);

    logic [addr_width-1:0] pc;
    logic                  epoch;
    logic [OW-1:0]         outstanding;
    logic                  stale_inflight;
    logic                  hold;

    logic [addr_width-1:0] tag_pc [MAX_OUTSTANDING];
    logic                  tag_ep [MAX_OUTSTANDING];
    logic [TW-1:0]         tag_wr, tag_rd;

    logic [data_width-1:0] fifo_data [FIFO_DEPTH];
    logic [addr_width-1:0] fifo_pc   [FIFO_DEPTH];
    logic [FW-1:0]         fifo_wr, fifo_rd;
    logic [FW:0]           fifo_count;

    logic    resp, keep, pop, issue;
    int      out_after, fifo_after;
    logic [OW-1:0] out_next;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TLAST) ? '0 : p + 1'b1;
    endfunction

    assign inst_valid = (fifo_count != '0);
    assign inst_data  = fifo_data[fifo_rd];
    assign inst_pc    = fifo_pc[fifo_rd];

    // While hold is set every in-flight word is stale, even if its 1-bit epoch aliases the current one.
    always_comb begin
        resp       = ir_data_valid && ir_data_ready;
        keep       = resp && !redirect_valid && !hold && (tag_ep[tag_rd] == epoch);
        pop        = inst_valid && inst_ready;
        out_after  = int'(outstanding) - (resp ? 1 : 0);
        fifo_after = redirect_valid ? 0 : int'(fifo_count) + (keep ? 1 : 0) - (pop ? 1 : 0);
        issue      = !redirect_valid && !hold && (!ir_addr_valid || ir_addr_ready)
                     && (out_after < MAX_OUTSTANDING)
                     && (out_after + fifo_after < FIFO_DEPTH);
        out_next   = OW'(out_after + (issue ? 1 : 0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            epoch          <= 1'b0;
            outstanding    <= '0;
            stale_inflight <= 1'b0;
            hold           <= 1'b0;
            ir_addr_valid  <= 1'b0;
            ir_addr        <= RESET_PC;
            ir_data_ready  <= 1'b0;
            tag_wr         <= '0;
            tag_rd         <= '0;
            fifo_wr        <= '0;
            fifo_rd        <= '0;
            fifo_count     <= '0;
        end else begin
            ir_data_ready <= 1'b1;
            outstanding   <= out_next;

            if (redirect_valid) begin
                epoch <= ~epoch;
                pc    <= redirect_pc & ~ALIGN_MASK;
            end else if (issue) begin
                pc <= pc + PC_INC;
            end

            if (issue) begin
                ir_addr_valid <= 1'b1;
                ir_addr       <= pc;
                tag_wr        <= tag_inc(tag_wr);
            end else if (ir_addr_valid && ir_addr_ready) begin
                ir_addr_valid <= 1'b0;
            end

            if (resp)
                tag_rd <= tag_inc(tag_rd);

            // A second redirect with old-epoch words still in flight would alias; drain them first.
            if (out_next == '0) begin
                stale_inflight <= 1'b0;
                hold           <= 1'b0;
            end else if (redirect_valid) begin
                stale_inflight <= 1'b1;
                hold           <= stale_inflight || hold;
            end

            if (redirect_valid) begin
                fifo_wr <= '0;
                fifo_rd <= '0;
            end else begin
                if (keep) fifo_wr <= fifo_wr + 1'b1;
                if (pop)  fifo_rd <= fifo_rd + 1'b1;
            end
            fifo_count <= (FW+1)'(fifo_after);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_pc[tag_wr] <= pc;
            tag_ep[tag_wr] <= epoch;
        end
        if (keep) begin
            fifo_data[fifo_wr] <= ir_data;
            fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
        end
    end

`ifdef MINI_I_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            stat_dropped <= '0;
        else if (resp && !keep && stat_dropped != 16'hFFFF)
            stat_dropped <= stat_dropped + 16'd1;
    end
`endif

    a_resp_without_tag: assert property (@(posedge clk) disable iff (rst)
        ir_data_valid |-> (outstanding != '0));

endmodule
